// File: rtl/miner_pkg.sv
// Shared definitions for the nonce-space dispatcher: nonce width, FSM state
// encoding, default chunk size and a helper that builds the 65-bit chunk
// increment used by the wrap-detecting adder.
package miner_pkg;

  localparam int NONCE_W        = 64;
  localparam int CHUNK_LOG2_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  // 2^log2 as a NONCE_W+1 bit value so the adder's carry-out is the wrap flag.
  function automatic logic [NONCE_W:0] chunk_size(input int log2);
    return {{NONCE_W{1'b0}}, 1'b1} << log2;
  endfunction

endpackage

// File: rtl/miner_dispatch_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter. Grants the first
// requester at or after ptr, wrapping modulo N.
// Ports: req (N requests), ptr (start index) -> gnt (one-hot), gnt_idx, any.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Each requester's distance from ptr going forward; the smallest distance
  // wins. Iterating on constant indices keeps every select static.
  always_comb begin
    int w_best_d;
    int w_d;
    gnt      = '0;
    gnt_idx  = '0;
    any      = 1'b0;
    w_best_d = N;
    w_d      = 0;
    for (int k = 0; k < N; k++) begin
      w_d = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + N - int'(ptr));
      if (req[k] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        gnt      = '0;
        gnt[k]   = 1'b1;
        gnt_idx  = IW'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miner_dispatch.sv
// miner_dispatch: splits the 64-bit nonce space into 2^CHUNK_LOG2 chunks from
// a programmed base, deals them round-robin to idle cores, arbitrates
// solution reports, latches the winner and halts the core array.
// Ports: start/halt/start_nonce from the register file; core_start/core_base/
// core_halt to the cores; core_done/core_found/core_soln from the cores;
// busy/found/exhausted/solution/irq/chunks_issued status. All outputs are
// registered. Optional macro MINER_DISPATCH_STATS_EN enables the saturating
// chunks_issued counter; without it chunks_issued is tied to zero.
module miner_dispatch
  import miner_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CHUNK_LOG2 = CHUNK_LOG2_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt,
  input  logic [NONCE_W-1:0]           start_nonce,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NONCE_W-1:0]           core_base,
  output logic                         core_halt,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_soln,
  output logic                         busy,
  output logic                         found,
  output logic                         exhausted,
  output logic [NONCE_W-1:0]           solution,
  output logic                         irq,
  output logic [31:0]                  chunks_issued
);

  localparam int               IDX_W = $clog2(NUM_CORES);
  localparam logic [NONCE_W:0] CHUNK = chunk_size(CHUNK_LOG2);

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_CORES - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // Registered state
  dispatch_state_t        r_state;
  logic [NUM_CORES-1:0]   r_idle;
  logic [IDX_W-1:0]       r_disp_ptr;
  logic [IDX_W-1:0]       r_fnd_ptr;
  logic [NONCE_W-1:0]     r_next_nonce;
  logic                   r_wrap;
  logic [NUM_CORES-1:0]   r_core_start;
  logic [NONCE_W-1:0]     r_core_base;
  logic                   r_core_halt;
  logic                   r_busy;
  logic                   r_found;
  logic                   r_exhausted;
  logic [NONCE_W-1:0]     r_solution;
  logic                   r_irq;

  // Next-state values
  dispatch_state_t        w_state;
  logic [NUM_CORES-1:0]   w_idle;
  logic [IDX_W-1:0]       w_disp_ptr;
  logic [IDX_W-1:0]       w_fnd_ptr;
  logic [NONCE_W-1:0]     w_next_nonce;
  logic                   w_wrap;
  logic [NUM_CORES-1:0]   w_core_start;
  logic [NONCE_W-1:0]     w_core_base;
  logic                   w_core_halt;
  logic                   w_busy;
  logic                   w_found;
  logic                   w_exhausted;
  logic [NONCE_W-1:0]     w_solution;
  logic                   w_irq;
  logic                   w_accept;
  logic                   w_dispatch;

  // Arbitration
  logic [NUM_CORES-1:0]   w_disp_req;
  logic [NUM_CORES-1:0]   w_disp_gnt;
  logic [IDX_W-1:0]       w_disp_idx;
  logic                   w_disp_any;
  logic [NUM_CORES-1:0]   w_fnd_gnt;
  logic [IDX_W-1:0]       w_fnd_idx;
  logic                   w_fnd_any;
  logic [NONCE_W-1:0]     w_fnd_soln;
  logic [NONCE_W-1:0]     w_disp_base;
  logic [NONCE_W:0]       w_sum;

  // A job start dispatches in the same cycle it is accepted; every core is
  // free at that point (idle or halted), so the request vector is all ones
  // outside RUN regardless of stale idle bits left over in DONE.
  assign w_disp_req  = (r_state == RUN) ? r_idle : '1;
  assign w_disp_base = (r_state == RUN) ? r_next_nonce : start_nonce;
  assign w_sum       = {1'b0, w_disp_base} + CHUNK;

  rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .req     (w_disp_req),
    .ptr     (r_disp_ptr),
    .gnt     (w_disp_gnt),
    .gnt_idx (w_disp_idx),
    .any     (w_disp_any)
  );

  rr_arbiter #(.N(NUM_CORES)) u_fnd_arb (
    .req     (core_found),
    .ptr     (r_fnd_ptr),
    .gnt     (w_fnd_gnt),
    .gnt_idx (w_fnd_idx),
    .any     (w_fnd_any)
  );

  // One-hot mux of the winning core's solution slice.
  always_comb begin
    w_fnd_soln = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_fnd_gnt[i]) w_fnd_soln = w_fnd_soln | core_soln[i*NONCE_W +: NONCE_W];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state;
  end

  // FSM next-state and datapath updates
  always_comb begin
    w_state      = r_state;
    w_idle       = r_idle;
    w_disp_ptr   = r_disp_ptr;
    w_fnd_ptr    = r_fnd_ptr;
    w_next_nonce = r_next_nonce;
    w_wrap       = r_wrap;
    w_core_start = '0;
    w_core_base  = '0;
    w_core_halt  = 1'b0;
    w_found      = r_found;
    w_exhausted  = r_exhausted;
    w_solution   = r_solution;
    w_irq        = 1'b0;
    w_accept     = 1'b0;
    w_dispatch   = 1'b0;
    w_busy       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) w_accept = 1'b1;
      end
      RUN: begin
        // Completions only free the core from next cycle on: dispatch below
        // arbitrates over r_idle, never over this cycle's done pulses.
        w_idle = r_idle | core_done | core_found;
        if (w_fnd_any) begin
          w_solution  = w_fnd_soln;
          w_found     = 1'b1;
          w_core_halt = 1'b1;
          w_irq       = 1'b1;
          w_fnd_ptr   = inc_idx(w_fnd_idx);
          w_state     = DONE;
        end else if (halt) begin
          w_core_halt = 1'b1;
          w_state     = DRAIN;
        end else if (r_wrap && (&r_idle)) begin
          w_exhausted = 1'b1;
          w_irq       = 1'b1;
          w_state     = DONE;
        end else if (!r_wrap && w_disp_any) begin
          w_dispatch = 1'b1;
        end
      end
      DRAIN: begin
        w_idle  = '1;
        w_state = IDLE;
      end
      DONE: begin
        // Cores are halted; treat them all as free from here on.
        w_idle = '1;
        if (start)     w_accept = 1'b1;
        else if (halt) w_state  = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_accept) begin
      w_state     = RUN;
      w_found     = 1'b0;
      w_exhausted = 1'b0;
      w_solution  = '0;
      w_wrap      = 1'b0;
      w_idle      = '1;
      w_dispatch  = 1'b1;
    end

    if (w_dispatch) begin
      w_core_start = w_disp_gnt;
      w_core_base  = w_disp_base;
      w_idle       = w_idle & ~w_disp_gnt;
      w_next_nonce = w_sum[NONCE_W-1:0];
      // Carry-out means the space is used up; the last chunk may be short.
      w_wrap       = w_sum[NONCE_W];
      w_disp_ptr   = inc_idx(w_disp_idx);
    end

    w_busy = (w_state == RUN) || (w_state == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle       <= '1;
      r_disp_ptr   <= '0;
      r_fnd_ptr    <= '0;
      r_next_nonce <= '0;
      r_wrap       <= 1'b0;
      r_core_start <= '0;
      r_core_base  <= '0;
      r_core_halt  <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_solution   <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_idle       <= w_idle;
      r_disp_ptr   <= w_disp_ptr;
      r_fnd_ptr    <= w_fnd_ptr;
      r_next_nonce <= w_next_nonce;
      r_wrap       <= w_wrap;
      r_core_start <= w_core_start;
      r_core_base  <= w_core_base;
      r_core_halt  <= w_core_halt;
      r_busy       <= w_busy;
      r_found      <= w_found;
      r_exhausted  <= w_exhausted;
      r_solution   <= w_solution;
      r_irq        <= w_irq;
    end
  end

  assign core_start = r_core_start;
  assign core_base  = r_core_base;
  assign core_halt  = r_core_halt;
  assign busy       = r_busy;
  assign found      = r_found;
  assign exhausted  = r_exhausted;
  assign solution   = r_solution;
  assign irq        = r_irq;

`ifdef MINER_DISPATCH_STATS_EN
  logic [31:0] r_chunks;
  logic [31:0] w_chunks;

  // Cleared by an accepted start, then the start's own dispatch is counted.
  always_comb begin
    w_chunks = w_accept ? 32'd0 : r_chunks;
    if (w_dispatch && (w_chunks != 32'hFFFF_FFFF)) w_chunks = w_chunks + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chunks <= '0;
    else      r_chunks <= w_chunks;
  end

  assign chunks_issued = r_chunks;
`else
  assign chunks_issued = '0;
`endif

endmodule

// File: tb/tb_miner_dispatch.sv
module tb_miner_dispatch;

  localparam int N  = 4;
  localparam int CL = 8;

`ifdef MINER_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic            halt;
  logic [63:0]     start_nonce;
  logic [N-1:0]    core_start;
  logic [63:0]     core_base;
  logic            core_halt;
  logic [N-1:0]    core_done;
  logic [N-1:0]    core_found;
  logic [N*64-1:0] core_soln;
  logic            busy;
  logic            found;
  logic            exhausted;
  logic [63:0]     solution;
  logic            irq;
  logic [31:0]     chunks_issued;

  int total;
  int bad;

  miner_dispatch #(.NUM_CORES(N), .CHUNK_LOG2(CL)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt          (halt),
    .start_nonce   (start_nonce),
    .core_start    (core_start),
    .core_base     (core_base),
    .core_halt     (core_halt),
    .core_done     (core_done),
    .core_found    (core_found),
    .core_soln     (core_soln),
    .busy          (busy),
    .found         (found),
    .exhausted     (exhausted),
    .solution      (solution),
    .irq           (irq),
    .chunks_issued (chunks_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_soln(input int idx, input logic [63:0] val);
    core_soln[idx*64 +: 64] = val;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    start       = 1'b0;
    halt        = 1'b0;
    start_nonce = '0;
    core_done   = '0;
    core_found  = '0;
    core_soln   = '0;

    // Reset values
    tick(); tick();
    chk("rst_core_start", 64'(core_start), 64'h0);
    chk("rst_core_base",  core_base, 64'h0);
    chk("rst_core_halt",  64'(core_halt), 64'h0);
    chk("rst_busy",       64'(busy), 64'h0);
    chk("rst_found",      64'(found), 64'h0);
    chk("rst_exhausted",  64'(exhausted), 64'h0);
    chk("rst_solution",   solution, 64'h0);
    chk("rst_irq",        64'(irq), 64'h0);
    chk("rst_chunks",     64'(chunks_issued), 64'h0);
    rst = 1'b1;
    tick();

    // Job 1: four consecutive dispatches from 0x1000
    start = 1'b1; start_nonce = 64'h1000;
    tick();
    start = 1'b0;
    chk("j1_cs0",   64'(core_start), 64'b0001);
    chk("j1_base0", core_base, 64'h1000);
    chk("j1_busy",  64'(busy), 64'h1);
    tick();
    chk("j1_cs1",   64'(core_start), 64'b0010);
    chk("j1_base1", core_base, 64'h1100);
    tick();
    chk("j1_cs2",   64'(core_start), 64'b0100);
    chk("j1_base2", core_base, 64'h1200);
    tick();
    chk("j1_cs3",   64'(core_start), 64'b1000);
    chk("j1_base3", core_base, 64'h1300);
    tick();
    chk("j1_full",  64'(core_start), 64'h0);

    // core 2 done: idle bit registered, re-dispatch visible one cycle later
    core_done = 4'b0100;
    tick();
    core_done = '0;
    chk("redisp_not_same", 64'(core_start), 64'h0);
    tick();
    chk("redisp_cs",   64'(core_start), 64'b0100);
    chk("redisp_base", core_base, 64'h1400);
    chk("redisp_cnt",  64'(chunks_issued), STATS ? 64'd5 : 64'd0);
    tick();

    // Simultaneous finds on cores 1 and 3, fnd_ptr=0 -> core 1 wins
    core_found = 4'b1010;
    set_soln(1, 64'hAA);
    set_soln(3, 64'hBB);
    tick();
    core_found = '0;
    chk("fnd_found", 64'(found), 64'h1);
    chk("fnd_soln",  solution, 64'hAA);
    chk("fnd_irq",   64'(irq), 64'h1);
    chk("fnd_halt",  64'(core_halt), 64'h1);
    chk("fnd_busy",  64'(busy), 64'h0);
    tick();
    chk("fnd_irq_once",  64'(irq), 64'h0);
    chk("fnd_halt_once", 64'(core_halt), 64'h0);
    chk("fnd_hold",      64'(found), 64'h1);

    // A find outside RUN is ignored
    core_found = 4'b0001;
    set_soln(0, 64'h55);
    tick();
    core_found = '0;
    chk("done_ign_found", solution, 64'hAA);

    // Restart from DONE; dispatch pointer continues at core 3
    start = 1'b1; start_nonce = 64'h2000;
    tick();
    start = 1'b0;
    chk("j2_cs",       64'(core_start), 64'b1000);
    chk("j2_base",     core_base, 64'h2000);
    chk("j2_clr_fnd",  64'(found), 64'h0);
    chk("j2_clr_soln", solution, 64'h0);
    chk("j2_cnt",      64'(chunks_issued), STATS ? 64'd1 : 64'd0);
    // Same finders again, fnd_ptr now 2 -> core 3 wins; no dispatch that cycle
    core_found = 4'b1010;
    tick();
    core_found = '0;
    chk("j2_soln",    solution, 64'hBB);
    chk("j2_found",   64'(found), 64'h1);
    chk("j2_nodisp",  64'(core_start), 64'h0);
    tick();

    // Exhaustion: two chunks fit before the 64-bit space wraps
    start = 1'b1; start_nonce = 64'hFFFF_FFFF_FFFF_FE00;
    tick();
    start = 1'b0;
    chk("ex_cs0",   64'(core_start), 64'b0001);
    chk("ex_base0", core_base, 64'hFFFF_FFFF_FFFF_FE00);
    tick();
    chk("ex_cs1",   64'(core_start), 64'b0010);
    chk("ex_base1", core_base, 64'hFFFF_FFFF_FFFF_FF00);
    tick();
    chk("ex_wrap_stop", 64'(core_start), 64'h0);
    tick();
    chk("ex_wrap_stop2", 64'(core_start), 64'h0);
    chk("ex_busy",       64'(busy), 64'h1);
    core_done = 4'b0011;
    tick();
    core_done = '0;
    chk("ex_not_yet", 64'(exhausted), 64'h0);
    tick();
    chk("ex_exh",   64'(exhausted), 64'h1);
    chk("ex_irq",   64'(irq), 64'h1);
    chk("ex_found", 64'(found), 64'h0);
    chk("ex_busy0", 64'(busy), 64'h0);
    tick();
    chk("ex_irq_once", 64'(irq), 64'h0);
    chk("ex_hold",     64'(exhausted), 64'h1);

    // Halt and find in the same cycle: find wins
    start = 1'b1; start_nonce = 64'h0;
    tick();
    start = 1'b0;
    chk("hf_cs",  64'(core_start), 64'b0100);
    chk("hf_exh", 64'(exhausted), 64'h0);
    halt = 1'b1; core_found = 4'b0001;
    set_soln(0, 64'h77);
    tick();
    halt = 1'b0; core_found = '0;
    chk("hf_found", 64'(found), 64'h1);
    chk("hf_soln",  solution, 64'h77);
    chk("hf_halt",  64'(core_halt), 64'h1);
    chk("hf_busy",  64'(busy), 64'h0);
    // Halt in DONE returns to IDLE, results kept
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("done_halt_keep", solution, 64'h77);
    chk("done_halt_nopulse", 64'(core_halt), 64'h0);

    // Halt alone mid-RUN
    start = 1'b1; start_nonce = 64'h5000;
    tick();
    start = 1'b0;
    chk("h_cs",   64'(core_start), 64'b1000);
    chk("h_base", core_base, 64'h5000);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_core_halt", 64'(core_halt), 64'h1);
    chk("h_nodisp",    64'(core_start), 64'h0);
    chk("h_drain",     64'(busy), 64'h1);
    tick();
    chk("h_idle",      64'(busy), 64'h0);
    chk("h_halt_once", 64'(core_halt), 64'h0);
    chk("h_found0",    64'(found), 64'h0);
    core_found = 4'b0001;
    tick();
    core_found = '0;
    chk("idle_ign_found", 64'(found), 64'h0);

    // Reset mid-RUN, then a fresh start dispatches from core 0
    start = 1'b1; start_nonce = 64'h100;
    tick();
    start = 1'b0;
    chk("r_cs0", 64'(core_start), 64'b0001);
    tick();
    chk("r_cs1", 64'(core_start), 64'b0010);
    #2 rst = 1'b0;
    #1;
    chk("r_async_cs",   64'(core_start), 64'h0);
    chk("r_async_base", core_base, 64'h0);
    chk("r_async_busy", 64'(busy), 64'h0);
    chk("r_async_cnt",  64'(chunks_issued), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1; start_nonce = 64'h100;
    tick();
    start = 1'b0;
    chk("r_new_cs",   64'(core_start), 64'b0001);
    chk("r_new_base", core_base, 64'h100);
    chk("r_new_halt", 64'(core_halt), 64'h0);
    chk("r_new_cnt",  64'(chunks_issued), STATS ? 64'd1 : 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
